pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry in-order pipeline stage register (main + skid) with per-lane
// partial loads from a shadow copy, flush, and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int NLANES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLANES*DATA_W-1:0] in_data,
    input  logic [NLANES-1:0]        in_lane_load,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLANES*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [15:0]              stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                    state_q;
    logic [NLANES*DATA_W-1:0]  main_q;
    logic [NLANES*DATA_W-1:0]  skid_q;
    logic [NLANES*DATA_W-1:0]  shadow_q;
    logic [NLANES*DATA_W-1:0]  entry_d;
    logic [15:0]               stall_q;
    logic                      accept;
    logic                      drain;

    // Handshake flags come only from registered state so in_ready never
    // depends combinationally on out_ready.
    assign occupancy   = state_q;
    assign in_ready    = (state_q != TWO);
    assign out_valid   = (state_q != EMPTY);
    assign out_data    = main_q;
    assign stall_count = stall_q;

    assign accept = in_valid && in_ready && !flush;
    assign drain  = out_valid && out_ready && !flush;

    // Lanes not loaded this accept keep the value of the last accepted entry.
    always_comb begin
        entry_d = shadow_q;
        for (int i = 0; i < NLANES; i++) begin
            if (in_lane_load[i]) begin
                entry_d[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            shadow_q <= '0;
            stall_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            if (accept) begin
                shadow_q <= entry_d;
            end
            if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= entry_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= entry_d;
                    end else if (accept) begin
                        skid_q  <= entry_d;
                        state_q <= TWO;
                    end else if (drain) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench for pipe_stage_reg: stimulus pushes expected
// entries, a negedge monitor pops and compares them as the DUT drains.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int NL = 4;
    localparam int W  = DW * NL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [NL-1:0] in_lane_load = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_count;

    int            checks = 0;
    int            errors = 0;

    // Reference model: entry count, lane shadow, stall counter, entry queue.
    int            modelCount = 0;
    logic [DW-1:0] shadowModel[NL];
    logic [15:0]   stallModel = '0;
    logic [W-1:0]  sbq[$];

    pipe_stage_reg #(.DATA_W(DW), .NLANES(NL)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lane_load (in_lane_load),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a drain happens at the next edge, so the head must match now.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_unexpected: got %h expected no entry", out_data);
            end else begin
                check("drain_data", out_data, sbq.pop_front());
            end
        end
    end

    task automatic checkOutput(input logic rstWas);
        check("occupancy", W'(occupancy), W'(modelCount));
        check("in_ready", W'(in_ready), W'(modelCount != 2));
        check("out_valid", W'(out_valid), W'(modelCount != 0));
        check("stall_count", W'(stall_count), W'(stallModel));
        if (rstWas) check("reset_out_data", out_data, '0);
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic v,
                                 input logic ordy, input logic [W-1:0] data,
                                 input logic [NL-1:0] load);
        logic [W-1:0] formed;
        int acc;
        int drn;
        reset        = rst;
        flush        = fl;
        in_valid     = v;
        out_ready    = ordy;
        in_data      = data;
        in_lane_load = load;
        if (rst) begin
            modelCount = 0;
            stallModel = '0;
            for (int i = 0; i < NL; i++) shadowModel[i] = '0;
            sbq.delete();
        end else if (fl) begin
            modelCount = 0;
            sbq.delete();
        end else begin
            acc = (v && modelCount != 2) ? 1 : 0;
            drn = (modelCount != 0 && ordy) ? 1 : 0;
            if (modelCount != 0 && !ordy && stallModel != 16'hFFFF) stallModel = stallModel + 16'd1;
            if (acc == 1) begin
                for (int i = 0; i < NL; i++) begin
                    if (load[i]) shadowModel[i] = data[i*DW +: DW];
                    formed[i*DW +: DW] = shadowModel[i];
                end
                sbq.push_back(formed);
            end
            modelCount = modelCount + acc - drn;
        end
        @(posedge clk);
        #1;
        checkOutput(rst);
    endtask

    function automatic logic [W-1:0] lanes(input int l0, input int l1, input int l2, input int l3);
        return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < NL; i++) shadowModel[i] = '0;
        a = lanes(1, 2, 3, 4);
        b = lanes(5, 6, 7, 8);

        applyStimulus(1, 0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0);

        // Single pass, then first-cycle-after-reset accept.
        applyStimulus(0, 0, 1, 1, a, 4'b1111);
        check("single_pass_data", out_data, a);
        applyStimulus(0, 0, 0, 1, '0, '0);

        // Back-pressure: two entries pile up, then drain in order.
        applyStimulus(0, 0, 1, 0, a, 4'b1111);
        applyStimulus(0, 0, 1, 0, b, 4'b1111);
        applyStimulus(0, 0, 1, 0, lanes(7, 7, 7, 7), 4'b1111);
        applyStimulus(0, 0, 0, 0, '0, '0);
        applyStimulus(0, 0, 0, 1, '0, '0);
        applyStimulus(0, 0, 0, 1, '0, '0);

        // Partial load: second entry becomes {9,2,9,4}.
        applyStimulus(0, 0, 1, 0, a, 4'b1111);
        applyStimulus(0, 0, 1, 0, lanes(9, 9, 9, 9), 4'b0101);
        applyStimulus(0, 0, 0, 1, '0, '0);
        check("partial_load_data", out_data, lanes(9, 2, 9, 4));
        applyStimulus(0, 0, 0, 1, '0, '0);

        // Flush in TWO with simultaneous input; shadow must survive.
        applyStimulus(0, 0, 1, 0, a, 4'b1111);
        applyStimulus(0, 0, 1, 0, b, 4'b1111);
        applyStimulus(0, 1, 1, 0, lanes(15, 15, 15, 15), 4'b1111);
        applyStimulus(0, 0, 1, 0, lanes(3, 3, 3, 3), 4'b0000);
        check("flush_shadow_data", out_data, b);
        applyStimulus(0, 0, 0, 1, '0, '0);

        // Reset in TWO.
        applyStimulus(0, 0, 1, 0, a, 4'b1111);
        applyStimulus(0, 0, 1, 0, b, 4'b1111);
        applyStimulus(1, 0, 1, 1, a, 4'b1111);
        applyStimulus(0, 0, 1, 1, b, 4'b0011);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(255) == 0), ($urandom_range(15) == 0),
                          1'($urandom), 1'($urandom),
                          {$urandom, $urandom}, 4'($urandom));
        end

        // Saturation of the stall counter.
        applyStimulus(0, 0, 1, 1, a, 4'b1111);
        for (int n = 0; n < 70000; n++) applyStimulus(0, 0, 0, 0, '0, '0);
        check("stall_saturated", W'(stall_count), W'(16'hFFFF));
        applyStimulus(0, 0, 0, 0, '0, '0);
        applyStimulus(0, 1, 0, 0, '0, '0);
        check("stall_after_flush", W'(stall_count), W'(16'hFFFF));

        for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1, '0, '0);
        check("scoreboard_empty", W'(sbq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
